// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: PC handshake with pcselect, instruction-memory
// SRAM-like port and the decode-side output queue.
interface fetch_ctrl_if;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_ready;
  logic        busy;

  modport master (
    output pc, inst_req, inst_addr, f_valid, f_pc, f_instr, busy,
    input  pc_next, redirect, redirect_pc, inst_addr_ok, inst_data_ok,
           inst_rdata, f_ready
  );

  modport slave (
    input  pc, inst_req, inst_addr, f_valid, f_pc, f_instr, busy,
    output pc_next, redirect, redirect_pc, inst_addr_ok, inst_data_ok,
           inst_rdata, f_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues credit-limited instruction
// requests, tracks in-flight PCs, buffers returns and squashes on redirect.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'hBFC0_0000,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic         clk,
  input  logic         resetn,
  fetch_ctrl_if.master bus
);
  localparam int unsigned PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {RUN, HOLD, HOLD_REDIR} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     redir_pc_q, redir_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic [PW-1:0]   pq_wr_q, pq_rd_q, frd_q, fwr_q;
  logic [PW-1:0]   frd_d, fwr_d;
  logic [31:0]     pq_mem_q [MAX_INFLIGHT];
  logic [31:0]     fpc_q    [MAX_INFLIGHT];
  logic [31:0]     finstr_q [MAX_INFLIGHT];

  logic credit_ok, req, acc, dok, drop, fpush, fpop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == MAX_INFLIGHT - 1) ? '0 : p + 1'b1;
  endfunction

  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fcnt_q}) < (CW+1)'(MAX_INFLIGHT);
  assign acc       = req & bus.inst_addr_ok;
  // Stray data_ok with nothing outstanding is ignored entirely.
  assign dok       = bus.inst_data_ok & (inflight_q != '0);
  assign drop      = dok & (discard_q != '0);
  assign fpush     = dok & ~drop & ~bus.redirect;
  assign fpop      = (fcnt_q != '0) & bus.f_ready & ~bus.redirect;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    req        = 1'b0;
    unique case (state_q)
      RUN: begin
        req = resetn & credit_ok & ~bus.redirect;
        if (bus.redirect)          pc_d    = bus.redirect_pc;
        else if (req) begin
          if (bus.inst_addr_ok)    pc_d    = bus.pc_next;
          else                     state_d = HOLD;
        end
      end
      HOLD: begin
        req = 1'b1;
        // Accepted together with a redirect: the fetch is stale and is
        // discarded through the redirect discard count below.
        if (bus.inst_addr_ok) begin
          pc_d    = bus.redirect ? bus.redirect_pc : bus.pc_next;
          state_d = RUN;
        end else if (bus.redirect) begin
          redir_pc_d = bus.redirect_pc;
          state_d    = HOLD_REDIR;
        end
      end
      HOLD_REDIR: begin
        req = 1'b1;
        if (bus.redirect) redir_pc_d = bus.redirect_pc;
        if (bus.inst_addr_ok) begin
          pc_d    = bus.redirect ? bus.redirect_pc : redir_pc_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q + CW'(acc) - CW'(dok);
    if (bus.redirect)
      discard_d = inflight_d;
    else
      discard_d = discard_q + CW'(acc && state_q == HOLD_REDIR) - CW'(drop);
    if (bus.redirect) begin
      fcnt_d = '0;
      frd_d  = '0;
      fwr_d  = '0;
    end else begin
      fcnt_d = fcnt_q + CW'(fpush) - CW'(fpop);
      frd_d  = fpop  ? ptr_inc(frd_q) : frd_q;
      fwr_d  = fpush ? ptr_inc(fwr_q) : fwr_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      redir_pc_q <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      fcnt_q     <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
      frd_q      <= '0;
      fwr_q      <= '0;
      for (int unsigned i = 0; i < MAX_INFLIGHT; i++) begin
        pq_mem_q[i] <= '0;
        fpc_q[i]    <= '0;
        finstr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      fcnt_q     <= fcnt_d;
      frd_q      <= frd_d;
      fwr_q      <= fwr_d;
      if (acc) begin
        pq_mem_q[pq_wr_q] <= pc_q;
        pq_wr_q           <= ptr_inc(pq_wr_q);
      end
      if (dok) pq_rd_q <= ptr_inc(pq_rd_q);
      if (fpush) begin
        fpc_q[fwr_q]    <= pq_mem_q[pq_rd_q];
        finstr_q[fwr_q] <= bus.inst_rdata;
      end
    end
  end

  assign bus.inst_req  = req;
  assign bus.pc        = pc_q;
  assign bus.inst_addr = pc_q;
  assign bus.f_valid   = (fcnt_q != '0);
  assign bus.f_pc      = fpc_q[frd_q];
  assign bus.f_instr   = finstr_q[frd_q];
  assign bus.busy      = (inflight_q != '0) || (discard_q != '0);

  a_no_stray_data_ok: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.inst_data_ok && inflight_q == '0));
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl (MAX_INFLIGHT=2): per-cycle inputs
// with hand-computed outputs, plus an asynchronous mid-stream reset.
module tb_fetch_ctrl;
  localparam logic [31:0] A0 = 32'hBFC0_0000;
  localparam logic [31:0] A1 = 32'hBFC0_0004;
  localparam logic [31:0] A2 = 32'hBFC0_0008;
  localparam logic [31:0] A3 = 32'hBFC0_000C;
  localparam logic [31:0] A4 = 32'hBFC0_0010;
  localparam logic [31:0] A5 = 32'hBFC0_0014;
  localparam logic [31:0] R  = 32'h8000_0180;
  localparam logic [31:0] X  = 32'h0;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(32'hBFC0_0000), .MAX_INFLIGHT(2)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  assign bus.pc_next = bus.pc + 32'd4;

  always #5 clk = ~clk;

  typedef struct {
    logic rst, aok, dok;
    logic [31:0] rdata;
    logic fr, redir;
    logic [31:0] rpc;
    logic req;
    logic [31:0] addr;
    logic fv;
    logic [31:0] fpc, finstr;
    logic busy;
  } vec_t;

  vec_t tv[$];

  task automatic v(input logic aok, dok, input logic [31:0] rdata,
                   input logic fr, redir, input logic [31:0] rpc,
                   input logic req, input logic [31:0] addr, input logic fv,
                   input logic [31:0] fpc, finstr, input logic busy);
    vec_t e;
    e.rst = 1'b0; e.aok = aok; e.dok = dok; e.rdata = rdata; e.fr = fr;
    e.redir = redir; e.rpc = rpc; e.req = req; e.addr = addr; e.fv = fv;
    e.fpc = fpc; e.finstr = finstr; e.busy = busy;
    tv.push_back(e);
  endtask

  task automatic rv();
    vec_t e;
    e.rst = 1'b1; e.aok = 1'b0; e.dok = 1'b0; e.rdata = X; e.fr = 1'b0;
    e.redir = 1'b0; e.rpc = X; e.req = 1'b0; e.addr = A0; e.fv = 1'b0;
    e.fpc = X; e.finstr = X; e.busy = 1'b0;
    tv.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
    bus.f_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;

    // Streaming with f_ready=1: credit throttles to inflight+fifo < 2
    rv();
    v(1,0,X,          1,0,X,   1,A0,0,X,A0,0);
    v(1,1,32'hA000_0000,1,0,X, 1,A1,0,X,X,1);
    v(1,1,32'hA000_0001,1,0,X, 0,A2,1,A0,32'hA000_0000,1);
    v(1,0,X,          1,0,X,   1,A2,1,A1,32'hA000_0001,0);
    v(1,1,32'hA000_0002,1,0,X, 1,A3,0,X,X,1);
    v(0,1,32'hA000_0003,1,0,X, 0,A4,1,A2,32'hA000_0002,1);
    // Credit exhaustion with f_ready=0, resume after first pop
    rv();
    v(1,0,X,          0,0,X,   1,A0,0,X,X,0);
    v(1,1,32'hB000_0000,0,0,X, 1,A1,0,X,X,1);
    v(1,1,32'hB000_0001,0,0,X, 0,A2,1,A0,32'hB000_0000,1);
    v(1,0,X,          0,0,X,   0,A2,1,A0,32'hB000_0000,0);
    v(1,0,X,          0,0,X,   0,A2,1,A0,32'hB000_0000,0);
    v(1,0,X,          1,0,X,   0,A2,1,A0,32'hB000_0000,0);
    v(1,0,X,          0,0,X,   1,A2,1,A1,32'hB000_0001,0);
    v(0,1,32'hB000_0002,0,0,X, 0,A3,1,A1,32'hB000_0001,1);
    // Redirect with two in flight: both returns dropped
    rv();
    v(1,0,X,          1,0,X,   1,A0,0,X,X,0);
    v(1,0,X,          1,0,X,   1,A1,0,X,X,1);
    v(1,0,X,          1,1,R,   0,A2,0,X,X,1);
    v(1,1,32'hC000_0001,1,0,X, 0,R,0,X,X,1);
    v(0,1,32'hC000_0002,1,0,X, 1,R,0,X,X,1);
    v(0,0,X,          1,0,X,   1,R,0,X,X,0);
    v(1,0,X,          1,0,X,   1,R,0,X,X,0);
    v(0,1,32'hC000_0000,1,0,X, 1,R+4,0,X,X,1);
    v(1,0,X,          1,0,X,   1,R+4,1,R,32'hC000_0000,0);
    // Redirect while a request is held: address stable, response discarded
    rv();
    v(0,0,X,          1,0,X,   1,A0,0,X,X,0);
    v(0,0,X,          1,1,32'hBFC0_0380, 1,A0,0,X,X,0);
    v(0,0,X,          1,0,X,   1,A0,0,X,X,0);
    v(1,0,X,          1,0,X,   1,A0,0,X,X,0);
    v(0,1,32'hDEAD_BEEF,1,0,X, 1,32'hBFC0_0380,0,X,X,1);
    v(1,0,X,          1,0,X,   1,32'hBFC0_0380,0,X,X,0);
    v(0,1,32'h1234_5678,1,0,X, 1,32'hBFC0_0384,0,X,X,1);
    v(0,0,X,          1,0,X,   1,32'hBFC0_0384,1,32'hBFC0_0380,32'h1234_5678,0);
    // Redirect coincident with last data_ok; then redirect vs f_ready
    rv();
    v(1,0,X,          1,0,X,   1,A0,0,X,X,0);
    v(0,1,32'h7777_7777,1,1,32'h8000_0000, 0,A1,0,X,X,1);
    v(0,0,X,          1,0,X,   1,32'h8000_0000,0,X,X,0);
    v(1,0,X,          1,0,X,   1,32'h8000_0000,0,X,X,0);
    v(0,1,32'h5555_AAAA,1,0,X, 1,32'h8000_0004,0,X,X,1);
    v(0,0,X,          0,0,X,   1,32'h8000_0004,1,32'h8000_0000,32'h5555_AAAA,0);
    v(0,0,X,          1,1,32'h9000_0000, 1,32'h8000_0004,1,32'h8000_0000,32'h5555_AAAA,0);
    v(0,0,X,          1,0,X,   1,32'h8000_0004,0,X,X,0);
    // Two in flight ahead of the asynchronous reset below
    rv();
    v(1,0,X,          0,0,X,   1,A0,0,X,X,0);
    v(1,0,X,          0,0,X,   1,A1,0,X,X,1);
    v(0,0,X,          0,0,X,   0,A2,0,X,X,1);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      resetn = ~tv[i].rst;
      bus.inst_addr_ok = tv[i].aok; bus.inst_data_ok = tv[i].dok;
      bus.inst_rdata = tv[i].rdata; bus.f_ready = tv[i].fr;
      bus.redirect = tv[i].redir; bus.redirect_pc = tv[i].rpc;
      #1;
      chk($sformatf("v%0d req", i),  32'(bus.inst_req), 32'(tv[i].req));
      chk($sformatf("v%0d addr", i), bus.inst_addr, tv[i].addr);
      chk($sformatf("v%0d pc", i),   bus.pc, tv[i].addr);
      chk($sformatf("v%0d fv", i),   32'(bus.f_valid), 32'(tv[i].fv));
      chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'(tv[i].busy));
      if (tv[i].fv || tv[i].rst) begin
        chk($sformatf("v%0d fpc", i),   bus.f_pc, tv[i].fpc);
        chk($sformatf("v%0d finstr", i), bus.f_instr, tv[i].finstr);
      end
    end

    // Asynchronous reset mid-cycle: outputs snap back without a clock edge
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("async req",  32'(bus.inst_req), 32'd0);
    chk("async addr", bus.inst_addr, A0);
    chk("async busy", 32'(bus.busy), 32'd0);
    chk("async fv",   32'(bus.f_valid), 32'd0);
    chk("async fpc",  bus.f_pc, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    bus.inst_addr_ok = 1'b1;
    #1;
    chk("post req",  32'(bus.inst_req), 32'd1);
    chk("post addr", bus.inst_addr, A0);
    @(negedge clk);
    #1;
    chk("post2 addr", bus.inst_addr, A1);
    chk("post2 busy", 32'(bus.busy), 32'd1);
    bus.inst_addr_ok = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
